// File: rtl/des_block_engine_if.sv
// Bus bundle between the block sequencer and its environment: command/status,
// the two block RAM ports and the round-core port.
interface des_block_engine_if #(
    parameter int ADDR_W  = 9,
    parameter int ROUND_W = 4
);
    logic               start;
    logic               abort;
    logic [ADDR_W-1:0]  num_blocks;
    logic               mode_cbc;
    logic               decrypt;
    logic [63:0]        iv;
    logic [ADDR_W-1:0]  in_addr;
    logic [31:0]        in_data;
    logic [ADDR_W-1:0]  out_addr;
    logic               out_we;
    logic [31:0]        out_data;
    logic [63:0]        core_in;
    logic [ROUND_W-1:0] core_round;
    logic               core_decrypt;
    logic [63:0]        core_out;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [ADDR_W-1:0]  blocks_done;

    // Environment side: issues commands, owns the RAMs and the round core.
    modport master (
        output start, abort, num_blocks, mode_cbc, decrypt, iv, in_data, core_out,
        input  in_addr, out_addr, out_we, out_data, core_in, core_round, core_decrypt,
        input  busy, done, aborted, blocks_done
    );

    // Sequencer side.
    modport slave (
        input  start, abort, num_blocks, mode_cbc, decrypt, iv, in_data, core_out,
        output in_addr, out_addr, out_we, out_data, core_in, core_round, core_decrypt,
        output busy, done, aborted, blocks_done
    );
endinterface

// File: rtl/des_block_engine.sv
// Streams 64-bit blocks from the input RAM through the iterated DES round core
// (ECB or CBC) into the output RAM, with block count, abort and progress status.
module des_block_engine #(
    parameter int ADDR_W  = 9,
    parameter int ROUNDS  = 16,
    parameter int ROUND_W = 4
) (
    input logic               i_sys_clk,
    input logic               i_reset_n,
    des_block_engine_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, LD_LO, LD_HI, LD_WAIT, ROUND, WR_LO, WR_HI, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0]  MAX_COUNT  = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]  CNT_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);

    state_t             r_state;
    logic               r_modeCbc;
    logic               r_decrypt;
    logic [63:0]        r_chain;
    logic [ADDR_W-1:0]  r_count;
    logic [ADDR_W-1:0]  r_blocksDone;
    logic [31:0]        r_loWord;
    logic [63:0]        r_plain;
    logic [31:0]        r_resHi;
    logic [ADDR_W-1:0]  r_inAddr;
    logic [ADDR_W-1:0]  r_outAddr;
    logic               r_outWe;
    logic [31:0]        r_outData;
    logic [63:0]        r_coreIn;
    logic [ROUND_W-1:0] r_coreRound;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;

    logic [ADDR_W-1:0]  w_count;
    logic [ADDR_W-2:0]  w_blockIdx;
    logic [ADDR_W-1:0]  w_addrLo;
    logic [ADDR_W-1:0]  w_addrHi;
    logic [63:0]        w_block;
    logic [63:0]        w_coreIn;
    logic [63:0]        w_result;

    // The block index is the number of blocks already written, so no separate k counter.
    assign w_count    = (bus.num_blocks > MAX_COUNT) ? MAX_COUNT : bus.num_blocks;
    assign w_blockIdx = r_blocksDone[ADDR_W-2:0];
    assign w_addrLo   = {w_blockIdx, 1'b0};
    assign w_addrHi   = {w_blockIdx, 1'b1};
    assign w_block    = {bus.in_data, r_loWord};
    assign w_coreIn   = (r_modeCbc && !r_decrypt) ? (w_block ^ r_chain) : w_block;
    assign w_result   = (r_modeCbc && r_decrypt) ? (bus.core_out ^ r_chain) : bus.core_out;

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_modeCbc    <= 1'b0;
            r_decrypt    <= 1'b0;
            r_chain      <= '0;
            r_count      <= '0;
            r_blocksDone <= '0;
            r_loWord     <= '0;
            r_plain      <= '0;
            r_resHi      <= '0;
            r_inAddr     <= '0;
            r_outAddr    <= '0;
            r_outWe      <= 1'b0;
            r_outData    <= '0;
            r_coreIn     <= '0;
            r_coreRound  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (bus.abort && (r_state != IDLE)) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_outWe     <= 1'b0;
                r_coreRound <= '0;
                r_aborted   <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_modeCbc    <= bus.mode_cbc;
                            r_decrypt    <= bus.decrypt;
                            r_chain      <= bus.iv;
                            r_count      <= w_count;
                            r_blocksDone <= '0;
                            r_busy       <= 1'b1;
                            r_inAddr     <= '0;
                            if (w_count == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= LD_LO;
                            end
                        end
                    end
                    LD_LO: begin
                        r_inAddr <= w_addrHi;
                        r_state  <= LD_HI;
                    end
                    LD_HI: begin
                        r_loWord <= bus.in_data;
                        r_state  <= LD_WAIT;
                    end
                    LD_WAIT: begin
                        r_plain     <= w_block;
                        r_coreIn    <= w_coreIn;
                        r_coreRound <= '0;
                        r_state     <= ROUND;
                    end
                    ROUND: begin
                        if (r_coreRound == LAST_ROUND) begin
                            // CBC encrypt chains on ciphertext, CBC decrypt on the incoming block.
                            if (r_modeCbc) begin
                                r_chain <= r_decrypt ? r_plain : bus.core_out;
                            end
                            r_resHi     <= w_result[63:32];
                            r_outData   <= w_result[31:0];
                            r_outAddr   <= w_addrLo;
                            r_outWe     <= 1'b1;
                            r_coreRound <= '0;
                            r_state     <= WR_LO;
                        end else begin
                            r_coreRound <= r_coreRound + ROUND_ONE;
                        end
                    end
                    WR_LO: begin
                        r_outAddr <= w_addrHi;
                        r_outData <= r_resHi;
                        r_state   <= WR_HI;
                    end
                    WR_HI: begin
                        r_outWe      <= 1'b0;
                        r_blocksDone <= r_blocksDone + CNT_ONE;
                        r_state      <= NEXT;
                    end
                    NEXT: begin
                        if (r_blocksDone == r_count) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_inAddr <= w_addrLo;
                            r_state  <= LD_LO;
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_outWe <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_addr      = r_inAddr;
    assign bus.out_addr     = r_outAddr;
    assign bus.out_we       = r_outWe;
    assign bus.out_data     = r_outData;
    assign bus.core_in      = r_coreIn;
    assign bus.core_round   = r_coreRound;
    assign bus.core_decrypt = r_decrypt;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.blocks_done  = r_blocksDone;

endmodule

// File: tb/tb_des_block_engine.sv
// Randomized self-checking bench for des_block_engine with RAM models, an
// invertible stand-in round core and a block-level ECB/CBC reference model.
module tb_des_block_engine;

    localparam int ADDR_W  = 9;
    localparam int ROUNDS  = 16;
    localparam int ROUND_W = 4;
    localparam int BLK     = ROUNDS + 6;
    localparam int MAXB    = 1 << (ADDR_W - 1);
    localparam int WORDS   = 1 << ADDR_W;
    localparam logic [63:0] KEY = 64'hA5C3_1F27_9E4B_D068;
    localparam logic [63:0] CBC_IV = 64'h0011_2233_4455_6677;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_block_engine_if #(.ADDR_W(ADDR_W), .ROUND_W(ROUND_W)) bus ();

    des_block_engine #(.ADDR_W(ADDR_W), .ROUNDS(ROUNDS), .ROUND_W(ROUND_W)) dut (
        .i_sys_clk (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    logic [31:0] inMem  [WORDS];
    logic [31:0] outMem [WORDS];
    logic [31:0] expMem [WORDS];
    logic [31:0] plain  [8];
    int wrCount = 0;
    int stabErr = 0;
    logic [ADDR_W-1:0]  lastWrAddr;
    logic [63:0]        prevIn;
    logic [ROUND_W-1:0] prevRound;
    int testsRun = 0;
    int testsFailed = 0;

    // Stand-in cipher: byte rotate plus key whitening, exactly invertible.
    function automatic logic [63:0] coreFn(input logic [63:0] x, input logic dec);
        logic [63:0] t;
        if (!dec) begin
            t = {x[55:0], x[63:56]} ^ KEY;
        end else begin
            t = x ^ KEY;
            t = {t[7:0], t[63:8]};
        end
        return t;
    endfunction

    // Result is only meaningful on the last round; anything else is poison.
    assign bus.core_out = (bus.core_round == ROUND_W'(ROUNDS - 1)) ?
                          coreFn(bus.core_in, bus.core_decrypt) : 64'hBADC_0DE0_BADC_0DE0;

    always @(posedge clk) begin
        bus.in_data <= inMem[bus.in_addr];
        if (bus.out_we === 1'b1) begin
            outMem[bus.out_addr] <= bus.out_data;
            wrCount              <= wrCount + 1;
            lastWrAddr           <= bus.out_addr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.core_round != '0 &&
                (bus.core_in !== prevIn || bus.core_round != prevRound + ROUND_W'(1)))
                stabErr <= stabErr + 1;
            prevIn    <= bus.core_in;
            prevRound <= bus.core_round;
        end
    end

    task automatic randomizeInput();
        for (int i = 0; i < WORDS; i++) inMem[i] = $urandom;
    endtask

    // Block-level chaining rules applied to the first n blocks of inMem.
    task automatic buildExpected(input int n, input bit cbc, input bit dec, input logic [63:0] iv);
        logic [63:0] chain, p, c;
        chain = iv;
        for (int b = 0; b < n; b++) begin
            p = {inMem[2*b+1], inMem[2*b]};
            if (!cbc) begin
                c = coreFn(p, dec);
            end else if (!dec) begin
                c = coreFn(p ^ chain, 1'b0);
                chain = c;
            end else begin
                c = coreFn(p, 1'b1) ^ chain;
                chain = p;
            end
            expMem[2*b]   = c[31:0];
            expMem[2*b+1] = c[63:32];
        end
    endtask

    function automatic int countBad(input int words);
        int bad = 0;
        for (int i = 0; i < words; i++)
            if (outMem[i] !== expMem[i]) bad++;
        return bad;
    endfunction

    // Starts a job and watches it cycle by cycle; cycle 1 is the first after the start edge.
    task automatic runJob(input int n, input bit cbc, input bit dec, input logic [63:0] iv,
                          input int abortAt, input int startAt,
                          output int doneCyc, output int abortCyc, output int busyCyc,
                          output int wrDelta, output logic busyAtAbort);
        int wr0;
        wr0 = wrCount;
        bus.num_blocks = ADDR_W'(n);
        bus.mode_cbc   = cbc;
        bus.decrypt    = dec;
        bus.iv         = iv;
        bus.abort      = 1'b0;
        bus.start      = 1'b1;
        doneCyc = -1;
        abortCyc = -1;
        busyCyc = 0;
        busyAtAbort = 1'b1;
        for (int c = 1; c <= 7000; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busyCyc++;
            if (bus.done === 1'b1) doneCyc = c;
            if (bus.aborted === 1'b1) begin
                abortCyc = c;
                busyAtAbort = bus.busy;
            end
            bus.start = (c == startAt);
            bus.abort = (c == abortAt);
            if (c == 1) begin
                bus.num_blocks = ADDR_W'($urandom);
                bus.mode_cbc   = ~cbc;
                bus.decrypt    = ~dec;
                bus.iv         = ~iv;
            end
            if (doneCyc > 0 || abortCyc > 0) break;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        wrDelta = wrCount - wr0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: busy/done/aborted got %b%b%b want 000", bus.busy, bus.done, bus.aborted);
        end
        testsRun++;
        if (bus.out_we !== 1'b0 || bus.out_addr !== '0 || bus.out_data !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outport: we=%b addr=%0d data=%h want all 0", bus.out_we, bus.out_addr, bus.out_data);
        end
        testsRun++;
        if (bus.in_addr !== '0 || bus.blocks_done !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_addr: in_addr=%0d blocks_done=%0d want 0", bus.in_addr, bus.blocks_done);
        end
        testsRun++;
        if (bus.core_in !== '0 || bus.core_round !== '0 || bus.core_decrypt !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_core: in=%h round=%0d dec=%b want 0", bus.core_in, bus.core_round, bus.core_decrypt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ecb();
        int n, d, a, bsy, w;
        logic ba;
        for (int rep = 0; rep < 3; rep++) begin
            n = int'($urandom_range(1, 6));
            randomizeInput();
            buildExpected(n, 1'b0, rep[0], 64'd0);
            runJob(n, 1'b0, rep[0], 64'h0, -1, -1, d, a, bsy, w, ba);
            testsRun++;
            if (d !== 1 + n * BLK) begin
                testsFailed++;
                $display("[TB] FAIL ecb_done_cycle: n=%0d got %0d want %0d", n, d, 1 + n * BLK);
            end
            testsRun++;
            if (w !== 2 * n || lastWrAddr !== ADDR_W'(2 * n - 1)) begin
                testsFailed++;
                $display("[TB] FAIL ecb_writes: n=%0d got %0d writes last %0d want %0d last %0d", n, w, lastWrAddr, 2 * n, 2 * n - 1);
            end
            testsRun++;
            if (countBad(2 * n) !== 0) begin
                testsFailed++;
                $display("[TB] FAIL ecb_data: n=%0d dec=%0d got %0d bad words want 0", n, rep[0], countBad(2 * n));
            end
            testsRun++;
            if (bus.blocks_done !== ADDR_W'(n) || bsy !== d) begin
                testsFailed++;
                $display("[TB] FAIL ecb_status: blocks_done=%0d busy_cycles=%0d want %0d and %0d", bus.blocks_done, bsy, n, d);
            end
        end
    endtask

    task automatic test_cbc_roundtrip();
        int d, a, bsy, w;
        logic ba;
        logic [63:0] c0;
        randomizeInput();
        for (int i = 0; i < 8; i++) plain[i] = inMem[i];
        buildExpected(4, 1'b1, 1'b0, CBC_IV);
        runJob(4, 1'b1, 1'b0, CBC_IV, -1, -1, d, a, bsy, w, ba);
        testsRun++;
        if (countBad(8) !== 0 || d !== 1 + 4 * BLK) begin
            testsFailed++;
            $display("[TB] FAIL cbc_encrypt: got %0d bad words, done at %0d want 0 and %0d", countBad(8), d, 1 + 4 * BLK);
        end
        c0 = coreFn({plain[1], plain[0]} ^ CBC_IV, 1'b0);
        testsRun++;
        if ({outMem[1], outMem[0]} !== c0) begin
            testsFailed++;
            $display("[TB] FAIL cbc_block0: got %h want %h", {outMem[1], outMem[0]}, c0);
        end
        for (int i = 0; i < 8; i++) begin
            inMem[i]  = outMem[i];
            expMem[i] = plain[i];
        end
        runJob(4, 1'b1, 1'b1, CBC_IV, -1, -1, d, a, bsy, w, ba);
        testsRun++;
        if (countBad(8) !== 0 || w !== 8) begin
            testsFailed++;
            $display("[TB] FAIL cbc_roundtrip: got %0d bad words %0d writes want 0 and 8", countBad(8), w);
        end
    endtask

    task automatic test_zero_blocks();
        int d, a, bsy, w;
        logic ba;
        runJob(0, 1'b0, 1'b0, 64'h0, -1, -1, d, a, bsy, w, ba);
        testsRun++;
        if (d !== 1 || w !== 0 || bsy !== 1) begin
            testsFailed++;
            $display("[TB] FAIL zero_count: done=%0d writes=%0d busy=%0d want 1 0 1", d, w, bsy);
        end
    endtask

    task automatic test_full_range();
        int d, a, bsy, w;
        logic ba;
        int counts [2] = '{MAXB, 300};
        for (int t = 0; t < 2; t++) begin
            randomizeInput();
            buildExpected(MAXB, 1'b0, 1'b0, 64'd0);
            runJob(counts[t], 1'b0, 1'b0, 64'h0, -1, -1, d, a, bsy, w, ba);
            testsRun++;
            if (d !== 1 + MAXB * BLK || w !== 2 * MAXB) begin
                testsFailed++;
                $display("[TB] FAIL full_count: n=%0d done=%0d writes=%0d want %0d and %0d", counts[t], d, w, 1 + MAXB * BLK, 2 * MAXB);
            end
            testsRun++;
            if (lastWrAddr !== ADDR_W'(WORDS - 1) || countBad(WORDS) !== 0) begin
                testsFailed++;
                $display("[TB] FAIL full_data: n=%0d last=%0d bad=%0d want %0d and 0", counts[t], lastWrAddr, countBad(WORDS), WORDS - 1);
            end
        end
    endtask

    task automatic test_abort();
        int d, a, bsy, w;
        logic ba;
        randomizeInput();
        buildExpected(2, 1'b0, 1'b0, 64'd0);
        // Cycle 50 is inside ROUND of block 2 (its load starts at cycle 45).
        runJob(5, 1'b0, 1'b0, 64'h0, 50, -1, d, a, bsy, w, ba);
        testsRun++;
        if (a !== 51 || ba !== 1'b0 || d !== -1) begin
            testsFailed++;
            $display("[TB] FAIL abort_ack: aborted at %0d busy=%b done at %0d want 51 0 -1", a, ba, d);
        end
        testsRun++;
        if (w !== 4 || bus.blocks_done !== ADDR_W'(2) || countBad(4) !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_progress: writes=%0d blocks_done=%0d bad=%0d want 4 2 0", w, bus.blocks_done, countBad(4));
        end
        testsRun++;
        if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_pulse: aborted=%b busy=%b want 0 0", bus.aborted, bus.busy);
        end
        randomizeInput();
        buildExpected(2, 1'b0, 1'b1, 64'd0);
        runJob(2, 1'b0, 1'b1, 64'h0, -1, -1, d, a, bsy, w, ba);
        testsRun++;
        if (d !== 1 + 2 * BLK || w !== 4 || countBad(4) !== 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_restart: done=%0d writes=%0d bad=%0d want %0d 4 0", d, w, countBad(4), 1 + 2 * BLK);
        end
    endtask

    task automatic test_start_while_busy();
        int d, a, bsy, w;
        logic ba;
        randomizeInput();
        buildExpected(2, 1'b0, 1'b0, 64'd0);
        runJob(2, 1'b0, 1'b0, 64'h0, -1, 30, d, a, bsy, w, ba);
        testsRun++;
        if (d !== 1 + 2 * BLK || w !== 4 || countBad(4) !== 0) begin
            testsFailed++;
            $display("[TB] FAIL busy_start: done=%0d writes=%0d bad=%0d want %0d 4 0", d, w, countBad(4), 1 + 2 * BLK);
        end
    endtask

    task automatic test_reset_midrun();
        int d, a, bsy, w;
        logic ba;
        randomizeInput();
        bus.num_blocks = ADDR_W'(3);
        bus.mode_cbc   = 1'b1;
        bus.decrypt    = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (bus.busy !== 1'b0 || bus.out_we !== 1'b0 || bus.core_round !== '0 || bus.core_decrypt !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset_ctl: busy=%b we=%b round=%0d dec=%b want 0", bus.busy, bus.out_we, bus.core_round, bus.core_decrypt);
        end
        testsRun++;
        if (bus.in_addr !== '0 || bus.blocks_done !== '0 || bus.core_in !== '0 || bus.out_data !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset_data: in_addr=%0d blocks_done=%0d core_in=%h out_data=%h want 0", bus.in_addr, bus.blocks_done, bus.core_in, bus.out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        buildExpected(1, 1'b0, 1'b0, 64'd0);
        runJob(1, 1'b0, 1'b0, 64'h0, -1, -1, d, a, bsy, w, ba);
        testsRun++;
        if (d !== 1 + BLK || countBad(2) !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_recover: done=%0d bad=%0d want %0d 0", d, countBad(2), 1 + BLK);
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_blocks = '0;
        bus.mode_cbc   = 1'b0;
        bus.decrypt    = 1'b0;
        bus.iv         = '0;
        randomizeInput();
        test_reset();
        test_ecb();
        test_cbc_roundtrip();
        test_zero_blocks();
        test_full_range();
        test_abort();
        test_start_while_busy();
        test_reset_midrun();
        testsRun++;
        if (stabErr !== 0) begin
            testsFailed++;
            $display("[TB] FAIL core_in_stability: got %0d round violations want 0", stabErr);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
